// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and sizes for the row-multiplexed LED matrix scanner.
package led_matrix_pkg;

    localparam int LED_ROWS = 16;
    localparam int LED_COLS = 16;

    typedef logic [LED_ROWS-1:0][LED_COLS-1:0] led_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRIVE,
        BLANK
    } scan_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Frame-source / matrix-pin bundle of the LED matrix scanner.
interface led_matrix_scanner_if;
    import led_matrix_pkg::*;

    logic       en;
    led_frame_t frame_in;
    logic [15:0] row_sel;
    logic [15:0] col_grn;
    logic [3:0]  row_idx;
    logic        frame_done;

    modport master (
        output en, frame_in,
        input  row_sel, col_grn, row_idx, frame_done
    );

    modport slave (
        input  en, frame_in,
        output row_sel, col_grn, row_idx, frame_done
    );

endinterface

// File: rtl/led_matrix_scanner_counter.sv
// Up-counter with synchronous clear and a terminal-count flag against a run-time limit;
// one instance times both the row dwell and the inter-row blank.
module scan_tick_counter #(
    parameter int MAX   = 1,
    parameter int WIDTH = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/led_matrix_scanner.sv
// Scans a latched 16x16 frame onto a row-multiplexed LED matrix, one row per dwell period.
// Define LED_SCAN_BLANK_EN to insert an all-off blank period after every row.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input logic clk,
    input logic rst_n,
    led_matrix_scanner_if.slave bus
);

    localparam int CNT_MAX = max_int(DWELL_CYCLES, BLANK_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    scan_state_e state;
    scan_state_e state_next;
    led_frame_t  shadow;
    logic [3:0]  row_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_limit;
    logic tc;
    logic cnt_clear;
    logic cnt_inc;
    logic load_frame;
    logic row_adv;
    logic row_clear;
    logic last_row;

    assign last_row = (row_q == 4'd15);

`ifdef LED_SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    // The limit follows the state register only, so en never reaches frame_done.
    assign cnt_limit = (state == BLANK) ? BLANK_LAST : DWELL_LAST;
`else
    assign cnt_limit = DWELL_LAST;
`endif

    scan_tick_counter #(
        .MAX   (CNT_MAX),
        .WIDTH (CNT_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .limit (cnt_limit),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            row_q  <= 4'd0;
        end else begin
            state <= state_next;
            if (load_frame) begin
                shadow <= bus.frame_in;
            end
            if (load_frame || row_clear) begin
                row_q <= 4'd0;
            end else if (row_adv) begin
                row_q <= row_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        load_frame = 1'b0;
        row_adv    = 1'b0;
        row_clear  = 1'b0;
        if (!bus.en) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
            row_clear  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_next = LOAD;
                    cnt_clear  = 1'b1;
                end
                LOAD: begin
                    load_frame = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = DRIVE;
                end
                DRIVE: begin
                    cnt_inc = 1'b1;
                    if (tc) begin
                        cnt_clear = 1'b1;
`ifdef LED_SCAN_BLANK_EN
                        state_next = BLANK;
`else
                        if (last_row) begin
                            state_next = LOAD;
                        end else begin
                            row_adv = 1'b1;
                        end
`endif
                    end
                end
`ifdef LED_SCAN_BLANK_EN
                BLANK: begin
                    cnt_inc = 1'b1;
                    if (tc) begin
                        cnt_clear = 1'b1;
                        if (last_row) begin
                            state_next = LOAD;
                        end else begin
                            row_adv    = 1'b1;
                            state_next = DRIVE;
                        end
                    end
                end
`endif
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Pin outputs are a pure decode of state, row and counter registers.
    always_comb begin
        bus.row_sel    = 16'd0;
        bus.col_grn    = 16'd0;
        bus.row_idx    = 4'd0;
        bus.frame_done = 1'b0;
        case (state)
            DRIVE: begin
                bus.row_sel = 16'd1 << row_q;
                bus.col_grn = shadow[row_q];
                bus.row_idx = row_q;
`ifndef LED_SCAN_BLANK_EN
                bus.frame_done = last_row && tc;
`endif
            end
`ifdef LED_SCAN_BLANK_EN
            BLANK: begin
                bus.row_idx    = row_q;
                bus.frame_done = last_row && tc;
            end
`endif
            default: begin
                bus.row_sel = 16'd0;
            end
        endcase
    end

endmodule
